// File: rtl/chacha_pkg.sv
// Shared constants, state encoding and small helpers for the ChaCha block engine.
package chacha_pkg;

    localparam logic [7:0] ADDR_CTRL    = 8'h0a;
    localparam logic [7:0] ADDR_STATUS  = 8'h0b;
    localparam logic [7:0] ADDR_KEYLEN  = 8'h0c;
    localparam logic [7:0] ADDR_ROUNDS  = 8'h0d;
    localparam logic [7:0] ADDR_KEY0    = 8'h30;
    localparam logic [7:0] ADDR_NONCE0  = 8'h38;
    localparam logic [7:0] ADDR_NONCE2  = 8'h3a;
    localparam logic [7:0] ADDR_COUNTER = 8'h3b;
    localparam logic [7:0] ADDR_DIN0    = 8'h50;
    localparam logic [7:0] ADDR_DOUT0   = 8'h70;

    localparam int unsigned CTRL_INIT    = 0;
    localparam int unsigned CTRL_NEXT    = 1;
    localparam int unsigned STATUS_READY = 0;
    localparam int unsigned STATUS_VALID = 1;

    // Word 0 sits in bits [31:0].
    localparam logic [127:0] SIGMA = {32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};
    localparam logic [127:0] TAU   = {32'h6b206574, 32'h79622d36, 32'h3120646e, 32'h61707865};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ROUNDS,
        ST_FINAL
    } state_t;

    function automatic logic [31:0] rotl32(input logic [31:0] x, input int unsigned n);
        return (x << n) | (x >> (32 - n));
    endfunction

    // Odd counts drop the LSB; counts below 2 fall back to the full 20 rounds.
    function automatic logic [4:0] eff_rounds(input logic [4:0] r);
        return (r < 5'd2) ? 5'd20 : {r[4:1], 1'b0};
    endfunction

endpackage

// File: rtl/chacha_qr.sv
// Combinational ChaCha quarter round on four 32-bit words.
module chacha_qr
    import chacha_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [31:0] c_i,
    input  logic [31:0] d_i,
    output logic [31:0] a_o,
    output logic [31:0] b_o,
    output logic [31:0] c_o,
    output logic [31:0] d_o
);

    logic [31:0] a1, b1, c1, d1;

    assign a1  = a_i + b_i;
    assign d1  = rotl32(d_i ^ a1, 16);
    assign c1  = c_i + d1;
    assign b1  = rotl32(b_i ^ c1, 12);
    assign a_o = a1 + b1;
    assign d_o = rotl32(d1 ^ a_o, 8);
    assign c_o = c1 + d_o;
    assign b_o = rotl32(b1 ^ c_o, 7);

endmodule

// File: rtl/chacha_cipher.sv
// ChaCha block engine behind a 32-bit chip-select register bus; one keystream block
// XORed onto a 512-bit input per run, half a double round per cycle.
module chacha_cipher
    import chacha_pkg::*;
#(
    parameter int unsigned DEFAULT_ROUNDS = 20,
    parameter bit          DEFAULT_KEYLEN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        we,
    input  logic [7:0]  addr,
    input  logic [31:0] write_data,
    output logic [31:0] read_data
);

    localparam logic [4:0] RST_ROUNDS = 5'(DEFAULT_ROUNDS);

    state_t      state_q, state_d;
    logic [31:0] key_q     [8];
    logic [31:0] nonce_q   [3];
    logic [31:0] counter_q;
    logic        keylen_q;
    logic [4:0]  rounds_q;
    logic [31:0] din_q     [16];
    logic [31:0] dout_q    [16];
    logic        dvalid_q;
    logic        mode_next_q;
    logic [31:0] blk_ctr_q;
    logic        blk_seen_q;
    logic [4:0]  nrounds_q, rcnt_q;
    logic [31:0] x_q       [16];
    logic [31:0] init_q    [16];
    logic [31:0] run_din_q [16];

    logic        wr, start, ready;
    logic [31:0] ctr_word;
    logic [31:0] init_w [16];
    logic [31:0] x_rnd  [16];
    logic [31:0] qa [4], qb [4], qc [4], qd [4];
    logic [31:0] ra [4], rb [4], rc [4], rd [4];
    logic [3:0]  ib [4], ic [4], id [4];

    assign ready = (state_q == ST_IDLE);
    assign wr    = cs & we;
    assign start = wr && (addr == ADDR_CTRL) && ready &&
                   (write_data[CTRL_INIT] || write_data[CTRL_NEXT]);

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_LOAD;
            ST_LOAD:   state_d = ST_ROUNDS;
            ST_ROUNDS: if (rcnt_q == nrounds_q - 5'd1) state_d = ST_FINAL;
            ST_FINAL:  state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // A "next" before any run has happened continues from the COUNTER register.
    always_comb begin
        if (!mode_next_q)    ctr_word = counter_q;
        else if (blk_seen_q) ctr_word = blk_ctr_q + 32'd1;
        else                 ctr_word = counter_q + 32'd1;
    end

    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            init_w[i]     = keylen_q ? SIGMA[32*i +: 32] : TAU[32*i +: 32];
            init_w[4 + i] = key_q[i];
            init_w[8 + i] = keylen_q ? key_q[4 + i] : key_q[i];
        end
        init_w[12] = ctr_word;
        for (int unsigned i = 0; i < 3; i++) init_w[13 + i] = nonce_q[i];
    end

    // Odd round cycles take the diagonals: lane k uses words k, 4+(k+1)%4, 8+(k+2)%4, 12+(k+3)%4.
    always_comb begin
        for (int unsigned k = 0; k < 4; k++) begin
            ib[k] = {2'b01, rcnt_q[0] ? 2'(k + 1) : 2'(k)};
            ic[k] = {2'b10, rcnt_q[0] ? 2'(k + 2) : 2'(k)};
            id[k] = {2'b11, rcnt_q[0] ? 2'(k + 3) : 2'(k)};
            qa[k] = x_q[k];
            qb[k] = x_q[ib[k]];
            qc[k] = x_q[ic[k]];
            qd[k] = x_q[id[k]];
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_qr
        chacha_qr u_qr (
            .a_i(qa[g]), .b_i(qb[g]), .c_i(qc[g]), .d_i(qd[g]),
            .a_o(ra[g]), .b_o(rb[g]), .c_o(rc[g]), .d_o(rd[g])
        );
    end

    always_comb begin
        x_rnd = x_q;
        for (int unsigned k = 0; k < 4; k++) begin
            x_rnd[k]     = ra[k];
            x_rnd[ib[k]] = rb[k];
            x_rnd[ic[k]] = rc[k];
            x_rnd[id[k]] = rd[k];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < 8; i++) key_q[i] <= '0;
            for (int unsigned i = 0; i < 3; i++) nonce_q[i] <= '0;
            for (int unsigned i = 0; i < 16; i++) begin
                din_q[i]     <= '0;
                dout_q[i]    <= '0;
                x_q[i]       <= '0;
                init_q[i]    <= '0;
                run_din_q[i] <= '0;
            end
            counter_q   <= '0;
            keylen_q    <= DEFAULT_KEYLEN;
            rounds_q    <= RST_ROUNDS;
            dvalid_q    <= 1'b0;
            mode_next_q <= 1'b0;
            blk_ctr_q   <= '0;
            blk_seen_q  <= 1'b0;
            nrounds_q   <= '0;
            rcnt_q      <= '0;
        end else begin
            if (wr) begin
                if (addr == ADDR_KEYLEN)               keylen_q <= write_data[0];
                if (addr == ADDR_ROUNDS)               rounds_q <= write_data[4:0];
                if (addr[7:3] == ADDR_KEY0[7:3])       key_q[addr[2:0]] <= write_data;
                if (addr >= ADDR_NONCE0 && addr <= ADDR_NONCE2)
                                                       nonce_q[addr[1:0]] <= write_data;
                if (addr == ADDR_COUNTER)              counter_q <= write_data;
                if (addr[7:4] == ADDR_DIN0[7:4])       din_q[addr[3:0]] <= write_data;
            end
            if (start) begin
                mode_next_q <= ~write_data[CTRL_INIT];
                dvalid_q    <= 1'b0;
            end
            case (state_q)
                ST_LOAD: begin
                    x_q        <= init_w;
                    init_q     <= init_w;
                    run_din_q  <= din_q;
                    nrounds_q  <= eff_rounds(rounds_q);
                    rcnt_q     <= '0;
                    blk_ctr_q  <= ctr_word;
                    blk_seen_q <= 1'b1;
                end
                ST_ROUNDS: begin
                    x_q    <= x_rnd;
                    rcnt_q <= rcnt_q + 5'd1;
                end
                ST_FINAL: begin
                    for (int unsigned i = 0; i < 16; i++)
                        dout_q[i] <= run_din_q[i] ^ (x_q[i] + init_q[i]);
                    dvalid_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        read_data = '0;
        if (cs) begin
            if (addr == ADDR_STATUS) begin
                read_data[STATUS_READY] = ready;
                read_data[STATUS_VALID] = dvalid_q;
            end
            else if (addr == ADDR_KEYLEN)                     read_data = {31'd0, keylen_q};
            else if (addr == ADDR_ROUNDS)                     read_data = {27'd0, rounds_q};
            else if (addr[7:3] == ADDR_KEY0[7:3])             read_data = key_q[addr[2:0]];
            else if (addr >= ADDR_NONCE0 && addr <= ADDR_NONCE2) read_data = nonce_q[addr[1:0]];
            else if (addr == ADDR_COUNTER)                    read_data = counter_q;
            else if (addr[7:4] == ADDR_DIN0[7:4])             read_data = din_q[addr[3:0]];
            else if (addr[7:4] == ADDR_DOUT0[7:4])            read_data = dout_q[addr[3:0]];
        end
    end

endmodule

// File: tb/tb_chacha_cipher.sv
// Self-checking bench: block-level reference model plus directed RFC 7539 vectors.
module tb_chacha_cipher;

    logic        clk = 1'b0;
    logic        reset, cs, we;
    logic [7:0]  addr;
    logic [31:0] write_data, read_data;

    always #5 clk = ~clk;

    chacha_cipher #(.DEFAULT_ROUNDS(20), .DEFAULT_KEYLEN(1'b1)) dut (
        .clk(clk), .reset(reset), .cs(cs), .we(we),
        .addr(addr), .write_data(write_data), .read_data(read_data)
    );

    int checks   = 0;
    int failures = 0;

    // ---------------- reference model ----------------
    function automatic logic [127:0] ref_qr(input logic [31:0] a, b, c, d);
        a += b; d ^= a; d = {d[15:0], d[31:16]};
        c += d; b ^= c; b = {b[19:0], b[31:20]};
        a += b; d ^= a; d = {d[23:0], d[31:24]};
        c += d; b ^= c; b = {b[24:0], b[31:25]};
        return {a, b, c, d};
    endfunction

    function automatic logic [511:0] ref_block(input logic [255:0] key, input logic [95:0] nonce,
                                               input logic [31:0] ctr, input logic kl,
                                               input logic [4:0] rounds, input logic [511:0] din);
        logic [31:0]  s [16];
        logic [31:0]  x [16];
        logic [127:0] t;
        logic [511:0] o;
        int           nr;
        int           qi [8][4];
        qi = '{'{0,4,8,12}, '{1,5,9,13}, '{2,6,10,14}, '{3,7,11,15},
               '{0,5,10,15}, '{1,6,11,12}, '{2,7,8,13}, '{3,4,9,14}};
        s[0] = 32'h61707865;
        s[1] = kl ? 32'h3320646e : 32'h3120646e;
        s[2] = kl ? 32'h79622d32 : 32'h79622d36;
        s[3] = 32'h6b206574;
        for (int i = 0; i < 8; i++) s[4+i] = kl ? key[32*i +: 32] : key[32*(i%4) +: 32];
        s[12] = ctr;
        for (int i = 0; i < 3; i++) s[13+i] = nonce[32*i +: 32];
        nr = (rounds < 2) ? 20 : (int'(rounds) / 2) * 2;
        x = s;
        for (int r = 0; r < nr / 2; r++) begin
            for (int q = 0; q < 8; q++) begin
                t = ref_qr(x[qi[q][0]], x[qi[q][1]], x[qi[q][2]], x[qi[q][3]]);
                x[qi[q][0]] = t[127:96];
                x[qi[q][1]] = t[95:64];
                x[qi[q][2]] = t[63:32];
                x[qi[q][3]] = t[31:0];
            end
        end
        for (int i = 0; i < 16; i++) o[32*i +: 32] = din[32*i +: 32] ^ (x[i] + s[i]);
        return o;
    endfunction

    // Register-level shadow of the host-visible state.
    logic [255:0] sh_key;
    logic [95:0]  sh_nonce;
    logic [31:0]  sh_ctr;
    logic         sh_kl;
    logic [4:0]   sh_rounds;
    logic [511:0] sh_din, m_dout, m_pend;
    int           m_busy;
    logic         m_dv;
    logic [31:0]  m_prev;
    logic         m_prev_ok;
    logic         m_rdy;
    logic [31:0]  m_exp;

    task automatic model_reset();
        sh_key = '0; sh_nonce = '0; sh_ctr = '0; sh_kl = 1'b1; sh_rounds = 5'd20;
        sh_din = '0; m_dout = '0; m_pend = '0; m_busy = 0; m_dv = 1'b0;
        m_prev = '0; m_prev_ok = 1'b0;
    endtask

    task automatic model_write(input logic [7:0] a, input logic [31:0] d, input logic rdy);
        logic [31:0] c;
        int          eff;
        if (a == 8'h0a) begin
            if (rdy && (d[0] || d[1])) begin
                if (d[0])           c = sh_ctr;
                else if (m_prev_ok) c = m_prev + 32'd1;
                else                c = sh_ctr + 32'd1;
                m_prev = c; m_prev_ok = 1'b1;
                m_pend = ref_block(sh_key, sh_nonce, c, sh_kl, sh_rounds, sh_din);
                eff = (sh_rounds < 2) ? 20 : (int'(sh_rounds) / 2) * 2;
                m_busy = eff + 2;
                m_dv = 1'b0;
            end
        end
        else if (a == 8'h0c)                 sh_kl = d[0];
        else if (a == 8'h0d)                 sh_rounds = d[4:0];
        else if (a >= 8'h30 && a <= 8'h37)   sh_key[32*int'(a - 8'h30) +: 32] = d;
        else if (a >= 8'h38 && a <= 8'h3a)   sh_nonce[32*int'(a - 8'h38) +: 32] = d;
        else if (a == 8'h3b)                 sh_ctr = d;
        else if (a >= 8'h50 && a <= 8'h5f)   sh_din[32*int'(a - 8'h50) +: 32] = d;
    endtask

    function automatic logic [31:0] model_read(input logic [7:0] a);
        if (a == 8'h0b)                    return {30'd0, m_dv, (m_busy == 0)};
        if (a == 8'h0c)                    return {31'd0, sh_kl};
        if (a == 8'h0d)                    return {27'd0, sh_rounds};
        if (a >= 8'h30 && a <= 8'h37)      return sh_key[32*int'(a - 8'h30) +: 32];
        if (a >= 8'h38 && a <= 8'h3a)      return sh_nonce[32*int'(a - 8'h38) +: 32];
        if (a == 8'h3b)                    return sh_ctr;
        if (a >= 8'h50 && a <= 8'h5f)      return sh_din[32*int'(a - 8'h50) +: 32];
        if (a >= 8'h70 && a <= 8'h7f)      return m_dout[32*int'(a - 8'h70) +: 32];
        return 32'd0;
    endfunction

    // Check the bus against the model, then advance the model over the coming edge.
    always @(negedge clk) begin
        if (!cs) begin
            checks++;
            if (read_data !== 32'd0) begin
                failures++;
                $display("FAIL bus_idle: read_data=%08h expected 00000000", read_data);
            end
        end else if (!we) begin
            m_exp = model_read(addr);
            checks++;
            if (read_data !== m_exp) begin
                failures++;
                $display("FAIL model_rd@%02h: read_data=%08h expected %08h", addr, read_data, m_exp);
            end
        end
        if (reset) model_reset();
        else begin
            m_rdy = (m_busy == 0);
            if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) begin m_dout = m_pend; m_dv = 1'b1; end
            end
            if (cs && we) model_write(addr, write_data, m_rdy);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        cs = 1'b1; we = 1'b1; addr = a; write_data = d;
        @(posedge clk); #1;
        cs = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] v);
        cs = 1'b1; we = 1'b0; addr = a;
        @(negedge clk); v = read_data;
        @(posedge clk); #1;
        cs = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk); #1;
    endtask

    task automatic wait_ready(output int n);
        logic [31:0] v;
        n = 0;
        for (int i = 0; i < 200; i++) begin
            rd(8'h0b, v);
            if (v[0]) return;
            n++;
        end
        checks++; failures++;
        $display("FAIL ready_timeout: ready still 0 after %0d polls, expected 1", n);
    endtask

    task automatic load_cfg(input logic [255:0] k, input logic [95:0] nn, input logic [31:0] c);
        for (int i = 0; i < 8; i++) wr(8'h30 + 8'(i), k[32*i +: 32]);
        for (int i = 0; i < 3; i++) wr(8'h38 + 8'(i), nn[32*i +: 32]);
        wr(8'h3b, c);
    endtask

    task automatic load_din(input logic [511:0] d);
        for (int i = 0; i < 16; i++) wr(8'h50 + 8'(i), d[32*i +: 32]);
    endtask

    task automatic chk_block(input string name, input logic [511:0] exp);
        logic [31:0] v;
        for (int i = 0; i < 16; i++) begin
            rd(8'h70 + 8'(i), v);
            chk($sformatf("%s_w%0d", name, i), v, exp[32*i +: 32]);
        end
    endtask

    logic [255:0] rfc_key;
    logic [95:0]  rfc_nonce;
    logic [511:0] ks1, ks2, ks0;
    logic [127:0] qt;
    logic [31:0]  v;
    int           n;

    initial begin
        cs = 1'b0; we = 1'b0; addr = '0; write_data = '0; reset = 1'b1;
        model_reset();
        for (int i = 0; i < 8; i++) rfc_key[32*i +: 32] = 32'h03020100 + 32'h04040404 * 32'(i);
        rfc_nonce = {32'h00000000, 32'h4a000000, 32'h09000000};
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        qt = ref_qr(32'h11111111, 32'h01020304, 32'h9b8d6f43, 32'h01234567);
        chk("ref_qr_a", qt[127:96], 32'hea2a92f4);
        chk("ref_qr_b", qt[95:64],  32'hcb1cf8ce);
        chk("ref_qr_c", qt[63:32],  32'h4581472e);
        chk("ref_qr_d", qt[31:0],   32'h5881c4bb);
        ks1 = ref_block(rfc_key, rfc_nonce, 32'd1, 1'b1, 5'd20, '0);
        ks2 = ref_block(rfc_key, rfc_nonce, 32'd2, 1'b1, 5'd20, '0);
        ks0 = ref_block(rfc_key, rfc_nonce, 32'd0, 1'b1, 5'd20, '0);
        chk("ref_blk_w0", ks1[31:0], 32'he4e7f110);

        rd(8'h0b, v); chk("rst_status", v, 32'h1);
        rd(8'h0d, v); chk("rst_rounds", v, 32'h14);
        rd(8'h0c, v); chk("rst_keylen", v, 32'h1);
        rd(8'h70, v); chk("rst_dout0", v, 32'h0);
        rd(8'h7f, v); chk("rst_dout15", v, 32'h0);
        rd(8'h00, v); chk("unmapped_00", v, 32'h0);
        wr(8'h75, 32'hdeadbeef);
        rd(8'h75, v); chk("ro_dout5", v, 32'h0);
        cs = 1'b0; addr = 8'h0d;
        @(negedge clk); chk("cs_low_read", read_data, 32'h0);
        idle();

        // RFC 7539 2.3.2 block.
        load_cfg(rfc_key, rfc_nonce, 32'd1);
        wr(8'h0a, 32'h1);
        wait_ready(n); chk("lat_20", 32'(n), 32'd22);
        rd(8'h0b, v); chk("status_done", v, 32'h3);
        rd(8'h70, v); chk("rfc_w0", v, 32'he4e7f110);
        rd(8'h71, v); chk("rfc_w1", v, 32'h15593bd1);
        rd(8'h72, v); chk("rfc_w2", v, 32'h1fdd0f50);
        rd(8'h73, v); chk("rfc_w3", v, 32'hc47120a3);

        load_din(ks1);
        wr(8'h0a, 32'h1);
        wait_ready(n);
        chk_block("xor_zero", '0);

        load_din('0);
        wr(8'h0a, 32'h2);
        wait_ready(n);
        chk_block("next_ctr2", ks2);

        // Start, then a second CTRL and a ROUNDS write while busy.
        wr(8'h0a, 32'h1);
        idle();
        wr(8'h0a, 32'h3);
        rd(8'h70, v); chk("busy_hold_dout0", v, ks2[31:0]);
        wr(8'h0d, 32'd8);
        wait_ready(n); chk("busy_ignore_lat", 32'(n), 32'd18);
        rd(8'h70, v); chk("busy_run_w0", v, 32'he4e7f110);
        rd(8'h0d, v); chk("busy_rounds_reg", v, 32'd8);

        wr(8'h0a, 32'h1);
        wait_ready(n); chk("lat_8", 32'(n), 32'd10);
        wr(8'h0c, 32'h0);
        wr(8'h0d, 32'd12);
        wr(8'h0a, 32'h1);
        wait_ready(n); chk("lat_12", 32'(n), 32'd14);
        wr(8'h0d, 32'd9);
        wr(8'h0a, 32'h2);
        wait_ready(n); chk("lat_odd9", 32'(n), 32'd10);
        wr(8'h0c, 32'h1);
        wr(8'h0d, 32'd1);
        wr(8'h0a, 32'h1);
        wait_ready(n); chk("lat_r1_as20", 32'(n), 32'd22);

        // Counter wrap on next with no prior run.
        reset = 1'b1; idle(); reset = 1'b0;
        load_cfg(rfc_key, rfc_nonce, 32'hffffffff);
        wr(8'h0a, 32'h2);
        wait_ready(n);
        chk_block("wrap_ctr0", ks0);
        wr(8'h0a, 32'h2);
        wait_ready(n);
        rd(8'h70, v); chk("after_wrap_w0", v, 32'he4e7f110);

        // Reset in the middle of a run.
        wr(8'h0a, 32'h1);
        repeat (5) idle();
        reset = 1'b1; idle(); reset = 1'b0;
        rd(8'h0b, v); chk("midrun_rst_status", v, 32'h1);
        rd(8'h70, v); chk("midrun_rst_dout0", v, 32'h0);
        rd(8'h0d, v); chk("midrun_rst_rounds", v, 32'h14);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
